map_streamer: RTL and testbench

MAP_STREAMER -- requirements
Module: map_streamer

---
 rtl/map_streamer.sv | 146 ++++++++++++++
 tb/tb_map_streamer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/map_streamer.sv
// rtl/map_streamer.sv - streams run-length map columns from a synchronous ROM on request
// Two-slot column buffer (cur/nxt) refilled by a FETCH/CAPTURE loop while STREAM serves reqs.
module map_streamer #(
  parameter int COL_W  = 100,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop_en,
  input  logic              req,
  output logic [COL_W-1:0]  col_out,
  output logic              col_valid,
  output logic              level_end,
  output logic              underrun,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W+7:0]  rom_data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_STREAM, S_END} state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [COL_W-1:0]   r_cur_pat;
  logic [COL_W-1:0]   r_nxt_pat;
  logic [7:0]         r_cur_rem;
  logic [7:0]         r_nxt_rem;
  logic               r_term;
  logic [ADDR_W-1:0]  r_ptr;

  logic [7:0]         w_len;
  logic [COL_W-1:0]   w_rom_pat;
  logic               w_serve;
  logic [COL_W-1:0]   w_cur_pat_a;
  logic [7:0]         w_cur_rem_a;
  logic [COL_W-1:0]   w_nxt_pat_a;
  logic [7:0]         w_nxt_rem_a;

  assign w_len     = rom_data[COL_W+7:COL_W];
  assign w_rom_pat = rom_data[COL_W-1:0];
  assign w_serve   = req && (r_state != S_IDLE) && (r_cur_rem != 8'd0);
  assign rom_en    = (r_state == S_FETCH);
  assign rom_addr  = r_ptr;

  // Buffer contents after this cycle's req; capture decisions use these so a
  // column consumed in the same cycle as a capture is never double-counted.
  always_comb begin
    w_cur_pat_a = r_cur_pat;
    w_cur_rem_a = r_cur_rem;
    w_nxt_pat_a = r_nxt_pat;
    w_nxt_rem_a = r_nxt_rem;
    if (w_serve) begin
      if (r_cur_rem == 8'd1) begin
        w_cur_pat_a = r_nxt_pat;
        w_cur_rem_a = r_nxt_rem;
        w_nxt_rem_a = 8'd0;
      end else begin
        w_cur_rem_a = r_cur_rem - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cur_pat <= '0;
      r_nxt_pat <= '0;
      r_cur_rem <= 8'd0;
      r_nxt_rem <= 8'd0;
      r_term    <= 1'b0;
      r_ptr     <= '0;
      col_out   <= '0;
      col_valid <= 1'b0;
      level_end <= 1'b0;
      underrun  <= 1'b0;
    end else if (start) begin
      r_state   <= S_FETCH;
      r_cur_pat <= '0;
      r_nxt_pat <= '0;
      r_cur_rem <= 8'd0;
      r_nxt_rem <= 8'd0;
      r_term    <= 1'b0;
      r_ptr     <= '0;
      col_valid <= 1'b0;
      level_end <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      col_valid <= 1'b0;
      if (req && r_state != S_IDLE) begin
        col_valid <= 1'b1;
        if (w_serve) begin
          col_out <= r_cur_pat;
        end else begin
          col_out <= '0;
          if (r_state != S_END) underrun <= 1'b1;
        end
      end
      r_cur_pat <= w_cur_pat_a;
      r_cur_rem <= w_cur_rem_a;
      r_nxt_pat <= w_nxt_pat_a;
      r_nxt_rem <= w_nxt_rem_a;
      case (r_state)
        S_IDLE: ;
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          if (w_len == 8'd0) begin
            // An entry-0 terminator means an empty map; looping it would spin forever.
            if (loop_en && r_ptr != '0) begin
              r_ptr   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_term  <= 1'b1;
              r_state <= S_STREAM;
            end
          end else begin
            r_ptr <= r_ptr + PTR_ONE;
            if (w_cur_rem_a == 8'd0) begin
              r_cur_pat <= w_rom_pat;
              r_cur_rem <= w_len;
              r_state   <= S_FETCH;
            end else begin
              r_nxt_pat <= w_rom_pat;
              r_nxt_rem <= w_len;
              r_state   <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (r_term) begin
            if (r_cur_rem == 8'd0 && r_nxt_rem == 8'd0) begin
              r_state   <= S_END;
              level_end <= 1'b1;
            end
          end else if (w_nxt_rem_a == 8'd0) begin
            r_state <= S_FETCH;
          end
        end
        S_END: level_end <= 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_streamer.sv
// tb/tb_map_streamer.sv - directed self-checking bench for map_streamer
module tb_map_streamer;

  localparam int COL_W = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, loop1 = 1'b0, req1 = 1'b0;
  logic start2 = 1'b0, loop2 = 1'b0, req2 = 1'b0;

  logic [COL_W-1:0] co1, co2;
  logic             cv1, cv2, le1, le2, ur1, ur2, re1, re2;
  logic [7:0]       ra1;
  logic [1:0]       ra2;
  logic [COL_W+7:0] rq1 = '0, rq2 = '0;
  logic [COL_W+7:0] mem1 [0:255];
  logic [COL_W+7:0] mem2 [0:3];

  int checks = 0;
  int failures = 0;

  logic [COL_W-1:0] pat_a, pat_b;
  logic             v;
  logic [COL_W-1:0] d;

  always #5 clk = ~clk;

  always @(posedge clk) if (re1) rq1 <= mem1[ra1];
  always @(posedge clk) if (re2) rq2 <= mem2[ra2];

  map_streamer #(.COL_W(COL_W), .ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start1), .loop_en(loop1), .req(req1),
    .col_out(co1), .col_valid(cv1), .level_end(le1), .underrun(ur1),
    .rom_en(re1), .rom_addr(ra1), .rom_data(rq1)
  );

  map_streamer #(.COL_W(COL_W), .ADDR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .loop_en(loop2), .req(req2),
    .col_out(co2), .col_valid(cv2), .level_end(le2), .underrun(ur2),
    .rom_en(re2), .rom_addr(ra2), .rom_data(rq2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic do_req(input bit sel, output logic ov, output logic [COL_W-1:0] od);
    @(negedge clk);
    if (sel) req2 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    req2 = 1'b0;
    ov = sel ? cv2 : cv1;
    od = sel ? co2 : co1;
  endtask

  initial begin
    logic [COL_W-1:0] exp7 [0:6];
    logic [COL_W-1:0] exp6 [0:5];

    pat_a = '0;
    pat_a[19:0] = 20'hFFFFF;
    pat_b = '0;
    pat_b[COL_W-1:COL_W-20] = 20'hFFFFF;
    for (int i = 0; i < 256; i++) mem1[i] = '0;
    mem1[0] = {8'd3, pat_a};
    mem1[1] = {8'd2, pat_b};
    for (int i = 0; i < 4; i++) mem2[i] = {8'd1, COL_W'((i + 1) * 17)};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_col_out", 128'(co1), 128'd0);
    check("rst_col_valid", 128'(cv1), 128'd0);
    check("rst_level_end", 128'(le1), 128'd0);
    check("rst_underrun", 128'(ur1), 128'd0);
    check("rst_rom_en", 128'(re1), 128'd0);
    check("rst_rom_addr", 128'(ra1), 128'd0);
    reset = 1'b0;

    // req in IDLE is ignored
    do_req(1'b0, v, d);
    check("idle_req_valid", 128'(v), 128'd0);

    // terminated map, loop_en=0
    loop1 = 1'b0;
    pulse_start(1'b0);
    repeat (8) @(negedge clk);
    exp6[0] = pat_a; exp6[1] = pat_a; exp6[2] = pat_a;
    exp6[3] = pat_b; exp6[4] = pat_b; exp6[5] = '0;
    for (int i = 0; i < 6; i++) begin
      repeat (7) @(negedge clk);
      do_req(1'b0, v, d);
      check($sformatf("end_valid%0d", i), 128'(v), 128'd1);
      check($sformatf("end_col%0d", i), 128'(d), 128'(exp6[i]));
      if (i == 4) begin
        check("end_le_at_last", 128'(le1), 128'd0);
        @(negedge clk);
        check("end_le_after_last", 128'(le1), 128'd1);
      end
    end
    check("end_le_hold", 128'(le1), 128'd1);
    check("end_underrun", 128'(ur1), 128'd0);

    // same map, looping
    loop1 = 1'b1;
    pulse_start(1'b0);
    repeat (8) @(negedge clk);
    exp7[0] = pat_a; exp7[1] = pat_a; exp7[2] = pat_a; exp7[3] = pat_b;
    exp7[4] = pat_b; exp7[5] = pat_a; exp7[6] = pat_a;
    for (int i = 0; i < 7; i++) begin
      repeat (7) @(negedge clk);
      do_req(1'b0, v, d);
      check($sformatf("loop_col%0d", i), 128'(d), 128'(exp7[i]));
    end
    check("loop_le", 128'(le1), 128'd0);

    // req immediately after start underruns
    loop1 = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    check("ur_valid", 128'(cv1), 128'd1);
    check("ur_col", 128'(co1), 128'd0);
    check("ur_flag", 128'(ur1), 128'd1);
    repeat (8) @(negedge clk);
    do_req(1'b0, v, d);
    check("ur_then_a", 128'(d), 128'(pat_a));

    // start and req together mid-stream
    @(negedge clk);
    start1 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    req1 = 1'b0;
    check("sr_valid", 128'(cv1), 128'd0);
    check("sr_underrun_clr", 128'(ur1), 128'd0);
    repeat (8) @(negedge clk);
    do_req(1'b0, v, d);
    check("sr_then_a", 128'(d), 128'(pat_a));

    // async reset mid-stream
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_col_out", 128'(co1), 128'd0);
    check("ar_col_valid", 128'(cv1), 128'd0);
    check("ar_level_end", 128'(le1), 128'd0);
    check("ar_underrun", 128'(ur1), 128'd0);
    check("ar_rom_en", 128'(re1), 128'd0);
    check("ar_rom_addr", 128'(ra1), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, v, d);
    check("ar_req_ignored", 128'(v), 128'd0);

    // 4-entry map, no terminator, pointer wraps
    pulse_start(1'b1);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      repeat (7) @(negedge clk);
      do_req(1'b1, v, d);
      check($sformatf("wrap_col%0d", i), 128'(d), 128'(((i % 4) + 1) * 17));
    end
    check("wrap_le", 128'(le2), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
